// File: rtl/shift_frame_ctrl.sv
// Serial framer that loads a byte into a downstream 8-bit shift register and frames its MSB stream
// as start / data / optional parity / stop bits on ser_out.
module shift_frame_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned SHIFT_FILL   = 0
) (
  input  logic       ck,
  input  logic       clr,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       q_msb,
  output logic [7:0] reg_d,
  output logic       reg_ld,
  output logic       reg_shl,
  output logic       reg_shin,
  output logic       reg_clr,
  output logic       ser_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned BAUD_W    = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_CLKS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              par_q, par_d;
  logic [7:0]        data_q, data_d;
  logic              bit_end;

  assign bit_end = (baud_q == BIT_LAST);

  // State and counter registers
  always_ff @(posedge ck) begin
    if (clr) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic; the baud counter restarts on every state change
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    par_d   = par_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (in_valid) begin
          data_d  = data_in;
          bit_d   = '0;
          par_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          par_d  = par_q ^ q_msb;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (baud_q == STOP_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state and counters
  always_comb begin
    in_ready   = (state_q == IDLE);
    busy       = (state_q != IDLE);
    reg_ld     = (state_q == LOAD);
    reg_shl    = (state_q == DATA) && bit_end;
    frame_done = (state_q == STOP) && (baud_q == STOP_LAST);
    reg_d      = data_q;
    reg_shin   = 1'(SHIFT_FILL);
    case (state_q)
      START:   ser_out = 1'b0;
      DATA:    ser_out = q_msb;
      PARITY:  ser_out = par_q ^ 1'(PARITY_ODD);
      default: ser_out = 1'b1;
    endcase
  end

  // Clearing the register at frame end leaves it zeroed for the next load
  assign reg_clr = clr | frame_done;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Directed bench: four framer configurations driven side by side, each feeding a behavioural
// model of the downstream 8-bit register; every cycle is checked against hand-derived framing.
module tb_shift_frame_ctrl;

  localparam int CPB  [4] = '{4, 4, 4, 1};
  localparam int PEN  [4] = '{1, 1, 0, 1};
  localparam int PODD [4] = '{0, 1, 0, 0};
  localparam int STP  [4] = '{1, 1, 1, 2};

  logic             ck;
  logic             clr;
  logic [7:0]       data_in;
  logic [3:0]       iv;
  logic [3:0]       rdy_w, ld_w, shl_w, shin_w, rclr_w, ser_w, busy_w, fd_w;
  logic [3:0][7:0]  rd_w;
  logic [3:0][7:0]  q_m;

  int vec_cnt;
  int err_cnt;

  shift_frame_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .SHIFT_FILL(0)) u_even (
    .ck(ck), .clr(clr), .data_in(data_in), .in_valid(iv[0]), .in_ready(rdy_w[0]), .q_msb(q_m[0][7]),
    .reg_d(rd_w[0]), .reg_ld(ld_w[0]), .reg_shl(shl_w[0]), .reg_shin(shin_w[0]), .reg_clr(rclr_w[0]),
    .ser_out(ser_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));

  shift_frame_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .SHIFT_FILL(0)) u_odd (
    .ck(ck), .clr(clr), .data_in(data_in), .in_valid(iv[1]), .in_ready(rdy_w[1]), .q_msb(q_m[1][7]),
    .reg_d(rd_w[1]), .reg_ld(ld_w[1]), .reg_shl(shl_w[1]), .reg_shin(shin_w[1]), .reg_clr(rclr_w[1]),
    .ser_out(ser_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));

  shift_frame_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .SHIFT_FILL(0)) u_nopar (
    .ck(ck), .clr(clr), .data_in(data_in), .in_valid(iv[2]), .in_ready(rdy_w[2]), .q_msb(q_m[2][7]),
    .reg_d(rd_w[2]), .reg_ld(ld_w[2]), .reg_shl(shl_w[2]), .reg_shin(shin_w[2]), .reg_clr(rclr_w[2]),
    .ser_out(ser_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));

  shift_frame_ctrl #(.CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .SHIFT_FILL(0)) u_fast (
    .ck(ck), .clr(clr), .data_in(data_in), .in_valid(iv[3]), .in_ready(rdy_w[3]), .q_msb(q_m[3][7]),
    .reg_d(rd_w[3]), .reg_ld(ld_w[3]), .reg_shl(shl_w[3]), .reg_shin(shin_w[3]), .reg_clr(rclr_w[3]),
    .ser_out(ser_w[3]), .busy(busy_w[3]), .frame_done(fd_w[3]));

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Downstream loadable/shiftable register, one per instance
  always @(posedge ck) begin
    for (int i = 0; i < 4; i++) begin
      if (rclr_w[i])     q_m[i] <= 8'h00;
      else if (ld_w[i])  q_m[i] <= rd_w[i];
      else if (shl_w[i]) q_m[i] <= {q_m[i][6:0], shin_w[i]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int frame_len(input int i);
    return 1 + CPB[i] * (9 + PEN[i]) + STP[i] * CPB[i];
  endfunction

  // Expected {reg_d, ld, shl, ser, frame_done, busy, ready} in clock c after the handshake edge
  function automatic logic [13:0] exp_at(input int i, input int c, input logic [7:0] b);
    int t, bp, ph, len;
    logic ld, shl, ser, fd, bsy, rdy;
    len = frame_len(i);
    ld = 1'b0; shl = 1'b0; ser = 1'b1; fd = 1'b0; bsy = 1'b1; rdy = 1'b0;
    if (c > len) begin
      bsy = 1'b0;
      rdy = 1'b1;
    end else if (c == 1) begin
      ld = 1'b1;
    end else begin
      t  = c - 2;
      bp = t / CPB[i];
      ph = t % CPB[i];
      if (bp == 0) ser = 1'b0;
      else if (bp <= 8) begin
        ser = b[8 - bp];
        shl = (ph == CPB[i] - 1);
      end else if (PEN[i] != 0 && bp == 9) ser = (^b) ^ 1'(PODD[i]);
      else fd = (c == len);
    end
    return {b, ld, shl, ser, fd, bsy, rdy};
  endfunction

  // Handshake b1 on all instances at the next edge; with b2b, in_valid stays high to start b2
  task automatic run_frame(input logic [7:0] b1, input logic [7:0] b2, input bit b2b,
                           input int ncyc, input bit do_chk);
    logic [13:0]     e;
    logic [3:0]      e_ld, e_shl, e_ser, e_fd, e_bsy, e_rdy;
    logic [3:0][7:0] e_rd;
    int              shl_n [4];
    int              len;
    data_in = b1;
    iv      = 4'hF;
    @(posedge ck);
    #1;
    data_in = b2;
    if (!b2b) iv = 4'h0;
    for (int i = 0; i < 4; i++) shl_n[i] = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge ck);
      for (int i = 0; i < 4; i++) begin
        len = frame_len(i);
        if (!b2b || c <= len + 1) e = exp_at(i, c, b1);
        else                      e = exp_at(i, c - len - 1, b2);
        {e_rd[i], e_ld[i], e_shl[i], e_ser[i], e_fd[i], e_bsy[i], e_rdy[i]} = e;
        if (shl_w[i]) shl_n[i]++;
        if (b2b) iv[i] = (c <= len + 1);
      end
      if (do_chk) begin
        chk("reg_ld", 32'(ld_w), 32'(e_ld));
        chk("reg_shl", 32'(shl_w), 32'(e_shl));
        chk("ser_out", 32'(ser_w), 32'(e_ser));
        chk("frame_done", 32'(fd_w), 32'(e_fd));
        chk("reg_clr", 32'(rclr_w), 32'(e_fd));
        chk("busy", 32'(busy_w), 32'(e_bsy));
        chk("in_ready", 32'(rdy_w), 32'(e_rdy));
        chk("reg_d", rd_w, e_rd);
        chk("reg_shin", 32'(shin_w), 32'h0);
      end
    end
    iv = 4'h0;
    if (do_chk)
      for (int i = 0; i < 4; i++) chk("shl_count", 32'(shl_n[i]), b2b ? 32'd16 : 32'd8);
  endtask

  task automatic check_idle(input string tag, input logic [3:0] e_rclr);
    chk({tag, "_ld"}, 32'(ld_w), 32'h0);
    chk({tag, "_shl"}, 32'(shl_w), 32'h0);
    chk({tag, "_ser"}, 32'(ser_w), 32'hF);
    chk({tag, "_busy"}, 32'(busy_w), 32'h0);
    chk({tag, "_fd"}, 32'(fd_w), 32'h0);
    chk({tag, "_rdy"}, 32'(rdy_w), 32'hF);
    chk({tag, "_rclr"}, 32'(rclr_w), 32'(e_rclr));
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    clr     = 1'b1;
    iv      = 4'hF;
    data_in = 8'hB1;

    // Reset held for three cycles with in_valid asserted
    for (int k = 0; k < 3; k++) begin
      @(negedge ck);
      check_idle("rst", 4'hF);
      chk("rst_reg_d", rd_w, 32'h0);
    end
    @(negedge ck);
    clr = 1'b0;
    // First edge after reset release is the handshake for 8'hB1
    run_frame(8'hB1, 8'h00, 1'b0, 47, 1'b1);

    // Held in_valid: 8'h55 then 8'hAA with one idle cycle between frames
    @(negedge ck);
    run_frame(8'h55, 8'hAA, 1'b1, 93, 1'b1);

    @(negedge ck);
    run_frame(8'hFF, 8'h00, 1'b0, 47, 1'b1);

    // Abort mid-DATA after three bits of the CLKS_PER_BIT=4 instances
    @(negedge ck);
    run_frame(8'hB1, 8'h00, 1'b0, 17, 1'b0);
    @(negedge ck);
    chk("pre_abort_busy", 32'(busy_w[2:0]), 32'h7);
    clr = 1'b1;
    #1;
    chk("abort_rclr", 32'(rclr_w), 32'hF);
    @(negedge ck);
    clr = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge ck);
      if (k < 2) check_idle("abort", 4'h0);
      else chk("abort_fd", 32'(fd_w), 32'h0);
    end
    run_frame(8'hF1, 8'h00, 1'b0, 47, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
